// File: rtl/vga_view_pkg.sv
// ============================================================================
//  Module   : vga_view_pkg
//  Purpose  : Timing, grid constants and cell lookup shared by the viewer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package vga_view_pkg;

   localparam int H_VIS  = 640;
   localparam int H_FP   = 16;
   localparam int H_SYNC = 96;
   localparam int H_BP   = 48;
   localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;

   localparam int V_VIS  = 480;
   localparam int V_FP   = 10;
   localparam int V_SYNC = 2;
   localparam int V_BP   = 33;
   localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;

   localparam int BYTES_PER_ROW  = 7;
   localparam int NUM_BYTES      = 21;
   localparam int CELLS_PER_BYTE = 3;
   localparam int GRID_COLS      = BYTES_PER_ROW * CELLS_PER_BYTE;
   localparam int GRID_ROWS      = 2 * (NUM_BYTES / BYTES_PER_ROW);

   typedef logic [11:0] rgb444_t;

   // col = byte position within the text row, sel = 0 high / 1 low / 2 blank
   typedef struct packed {
      logic [2:0] col;
      logic [1:0] sel;
   } cell_t;

   function automatic cell_t cell_lut(input logic [4:0] cx);
      cell_t c;
      c = '0;
      for (int i = 0; i < GRID_COLS; i++) begin
         if (cx == 5'(i)) begin
            c.col = 3'(i / CELLS_PER_BYTE);
            c.sel = 2'(i % CELLS_PER_BYTE);
         end
      end
      return c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/hex_font_rom.sv
// ============================================================================
//  Module   : hex_font_rom
//  Purpose  : Combinational 8x8 glyphs for hex digits 0-F, bit 7 leftmost.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hex_font_rom (
   input  logic [3:0] nibble,
   input  logic [2:0] row,
   output logic [7:0] bits
);

   logic [63:0] w_glyph;

   // Glyph rows packed top row in the most significant byte
   always_comb begin
      w_glyph = '0;
      case (nibble)
         4'h0: w_glyph = 64'h3C666E7666663C00;
         4'h1: w_glyph = 64'h183818181818_7E00;
         4'h2: w_glyph = 64'h3C66060C30607E00;
         4'h3: w_glyph = 64'h3C66061C06663C00;
         4'h4: w_glyph = 64'h0C1C3C6C7E0C0C00;
         4'h5: w_glyph = 64'h7E607C0606663C00;
         4'h6: w_glyph = 64'h3C607C6666663C00;
         4'h7: w_glyph = 64'h7E060C1830303000;
         4'h8: w_glyph = 64'h3C66663C66663C00;
         4'h9: w_glyph = 64'h3C66663E060C3800;
         4'hA: w_glyph = 64'h183C66667E666600;
         4'hB: w_glyph = 64'h7C66667C66667C00;
         4'hC: w_glyph = 64'h3C66606060663C00;
         4'hD: w_glyph = 64'h786C6666666C7800;
         4'hE: w_glyph = 64'h7E60607C60607E00;
         4'hF: w_glyph = 64'h7E60607C60606000;
         default: w_glyph = '0;
      endcase
      bits = w_glyph[{~row, 3'b000} +: 8];
   end

endmodule

`default_nettype wire

// File: rtl/vga_mem_viewer.sv
// ============================================================================
//  Module   : vga_mem_viewer
//  Purpose  : 640x480@60 VGA text view of 21 memory bytes as hex digits.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_mem_viewer
   import vga_view_pkg::*;
#(
   parameter int      CLK_DIV = 2,
   parameter int      SCALE   = 2,
   parameter int      X0      = 32,
   parameter int      Y0      = 32,
   parameter rgb444_t FG      = 12'hFFF,
   parameter rgb444_t BG      = 12'h000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [167:0] mem_flat,
   output logic         hsync,
   output logic         vsync,
   output logic [3:0]   vga_r,
   output logic [3:0]   vga_g,
   output logic [3:0]   vga_b,
   output logic         frame_start
);

   localparam int              c_DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(CLK_DIV - 1);
   localparam int              c_SSH      = (SCALE >= 4) ? 2 : (SCALE >= 2) ? 1 : 0;
   localparam int              c_CSH      = c_SSH + 3;

   logic [c_DW-1:0]        r_div;
   logic [9:0]             r_h;
   logic [9:0]             r_v;
   logic [NUM_BYTES*8-1:0] r_snap;

   logic       r_s1_vis;
   logic       r_s1_grid;
   logic       r_s1_hi;
   logic       r_s1_hs;
   logic       r_s1_vs;
   logic [4:0] r_s1_idx;
   logic [2:0] r_s1_grow;
   logic [2:0] r_s1_gcol;

   rgb444_t r_rgb;
   logic    r_hs;
   logic    r_vs;

   logic       w_tick;
   logic       w_cap;
   logic [9:0] w_x;
   logic [9:0] w_y;
   logic [9:0] w_cx;
   logic [9:0] w_cy;
   cell_t      w_cell;
   logic       w_in_xy;
   logic       w_vis;
   logic       w_grid;
   logic       w_hs;
   logic       w_vs;
   logic [4:0] w_idx;
   logic [2:0] w_grow;
   logic [2:0] w_gcol;
   logic [7:0] w_byte;
   logic [3:0] w_nib;
   logic [7:0] w_bits;
   logic       w_on;

   assign w_tick      = (r_div == c_DIV_LAST);
   assign w_cap       = w_tick && (r_h == '0) && (r_v == 10'(V_VIS));
   assign frame_start = w_cap;

   // Stage 1: pixel position to cell, byte index and glyph coordinates
   always_comb begin
      w_x     = r_h - 10'(X0);
      w_y     = r_v - 10'(Y0);
      w_cx    = w_x >> c_CSH;
      w_cy    = w_y >> c_CSH;
      w_cell  = cell_lut(w_cx[4:0]);
      w_in_xy = (r_h >= 10'(X0)) && (r_v >= 10'(Y0));
      w_grid  = w_in_xy && (w_cx < 10'(GRID_COLS)) && (w_cy < 10'(GRID_ROWS))
                && !w_cy[0] && (w_cell.sel != 2'd2);
      w_idx   = w_grid ? (5'(w_cy[2:1]) * 5'(BYTES_PER_ROW) + 5'(w_cell.col)) : '0;
      w_grow  = 3'(w_y >> c_SSH);
      w_gcol  = 3'(w_x >> c_SSH);
      w_vis   = (r_h < 10'(H_VIS)) && (r_v < 10'(V_VIS));
      w_hs    = !((r_h >= 10'(H_VIS + H_FP)) && (r_h < 10'(H_VIS + H_FP + H_SYNC)));
      w_vs    = !((r_v >= 10'(V_VIS + V_FP)) && (r_v < 10'(V_VIS + V_FP + V_SYNC)));
   end

   // Stage 2: snapshot byte, nibble and glyph bit
   always_comb begin
      w_byte = r_snap[{r_s1_idx, 3'b000} +: 8];
      w_nib  = r_s1_hi ? w_byte[7:4] : w_byte[3:0];
      w_on   = w_bits[3'd7 - r_s1_gcol];
   end

   hex_font_rom u_font (
      .nibble (w_nib),
      .row    (r_s1_grow),
      .bits   (w_bits)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_div     <= '0;
         r_h       <= '0;
         r_v       <= '0;
         r_snap    <= '0;
         r_s1_vis  <= 1'b0;
         r_s1_grid <= 1'b0;
         r_s1_hi   <= 1'b0;
         r_s1_hs   <= 1'b1;
         r_s1_vs   <= 1'b1;
         r_s1_idx  <= '0;
         r_s1_grow <= '0;
         r_s1_gcol <= '0;
         r_rgb     <= '0;
         r_hs      <= 1'b1;
         r_vs      <= 1'b1;
      end else begin
         r_div <= w_tick ? '0 : r_div + 1'b1;
         if (w_tick) begin
            if (r_h == 10'(H_TOT - 1)) begin
               r_h <= '0;
               r_v <= (r_v == 10'(V_TOT - 1)) ? '0 : r_v + 10'd1;
            end else begin
               r_h <= r_h + 10'd1;
            end
            if (w_cap) begin
               r_snap <= mem_flat;
            end
            r_s1_vis  <= w_vis;
            r_s1_grid <= w_grid;
            r_s1_hi   <= (w_cell.sel == 2'd0);
            r_s1_hs   <= w_hs;
            r_s1_vs   <= w_vs;
            r_s1_idx  <= w_idx;
            r_s1_grow <= w_grow;
            r_s1_gcol <= w_gcol;
            r_rgb     <= !r_s1_vis ? '0 : (r_s1_grid && w_on) ? FG : BG;
            r_hs      <= r_s1_hs;
            r_vs      <= r_s1_vs;
         end
      end
   end

   assign hsync = r_hs;
   assign vsync = r_vs;
   assign vga_r = r_rgb[11:8];
   assign vga_g = r_rgb[7:4];
   assign vga_b = r_rgb[3:0];

endmodule

`default_nettype wire

// File: tb/tb_vga_mem_viewer.sv
// ============================================================================
//  Module   : tb_vga_mem_viewer
//  Purpose  : Scoreboard bench for the VGA memory viewer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vga_mem_viewer;

   localparam int CD    = 2;
   localparam int H_T   = 800;
   localparam int FRAME = 800 * 525;
   localparam int CAP   = 480 * 800;
   localparam int LIMIT = FRAME * CD * 2;
   localparam logic [11:0] FGC = 12'hEDC;
   localparam logic [11:0] BGC = 12'h123;

   localparam logic [63:0] FONT [16] = '{
      64'h3C666E7666663C00, 64'h1838181818187E00, 64'h3C66060C30607E00, 64'h3C66061C06663C00,
      64'h0C1C3C6C7E0C0C00, 64'h7E607C0606663C00, 64'h3C607C6666663C00, 64'h7E060C1830303000,
      64'h3C66663C66663C00, 64'h3C66663E060C3800, 64'h183C66667E666600, 64'h7C66667C66667C00,
      64'h3C66606060663C00, 64'h786C6666666C7800, 64'h7E60607C60607E00, 64'h7E60607C60606000};

   typedef struct packed {
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
   } pix_t;

   localparam pix_t RST_PIX = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1};

   logic         clk;
   logic         rst;
   logic [167:0] mem_flat;
   logic         hsync;
   logic         vsync;
   logic [3:0]   vga_r;
   logic [3:0]   vga_g;
   logic [3:0]   vga_b;
   logic         frame_start;

   int           n_total;
   int           n_bad;
   int           e;
   int           pos;
   int           fs_model;
   int           fs_dut;
   logic [167:0] m_snap;
   pix_t         sbq [$];

   vga_mem_viewer #(
      .CLK_DIV (CD),
      .SCALE   (2),
      .X0      (32),
      .Y0      (32),
      .FG      (FGC),
      .BG      (BGC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_flat    (mem_flat),
      .hsync       (hsync),
      .vsync       (vsync),
      .vga_r       (vga_r),
      .vga_g       (vga_g),
      .vga_b       (vga_b),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic pix_t exp_pix(input int p, input logic [167:0] snap);
      int         h, v, x, y, cx, cy, b, nib, gr, gc;
      logic [63:0] g;
      logic [7:0]  rowbits;
      pix_t        r;
      h     = p % H_T;
      v     = p / H_T;
      r.hs  = !(h >= 656 && h < 752);
      r.vs  = !(v == 490 || v == 491);
      r.rgb = 12'h000;
      if (h < 640 && v < 480) begin
         r.rgb = BGC;
         if (h >= 32 && v >= 32) begin
            x  = h - 32;
            y  = v - 32;
            cx = x / 16;
            cy = y / 16;
            if (cx < 21 && cy < 6 && cy % 2 == 0 && cx % 3 != 2) begin
               b       = 7 * (cy / 2) + cx / 3;
               nib     = (cx % 3 == 0) ? int'(snap[8*b+4 +: 4]) : int'(snap[8*b +: 4]);
               gr      = (y / 2) % 8;
               gc      = (x / 2) % 8;
               g       = FONT[nib];
               rowbits = g[63-8*gr -: 8];
               if (rowbits[7-gc]) r.rgb = FGC;
            end
         end
      end
      return r;
   endfunction

   // One clk of stimulus, model update and scoreboard pop
   task automatic step();
      pix_t exp_p;
      pix_t got;
      logic fs_exp;
      logic win;
      logic popped;
      @(posedge clk);
      popped = 1'b0;
      win    = 1'b0;
      exp_p  = RST_PIX;
      if (rst) begin
         e      = 0;
         pos    = 0;
         m_snap = '0;
         sbq.delete();
         sbq.push_back(RST_PIX);
      end else begin
         e++;
         if (e % CD == 0) begin
            if (pos == CAP) m_snap = mem_flat;
            win = (pos / H_T < 130) || (pos / H_T >= 476);
            sbq.push_back(exp_pix(pos, m_snap));
            pos    = (pos + 1) % FRAME;
            exp_p  = sbq.pop_front();
            popped = 1'b1;
         end
      end
      #1;
      got = {vga_r, vga_g, vga_b, hsync, vsync};
      if (popped && win) check("pix", 32'(got), 32'(exp_p));
      fs_exp = !rst && ((e + 1) % CD == 0) && (pos == CAP);
      if (fs_exp) fs_model++;
      if (frame_start) fs_dut++;
      if (pos / H_T >= 476) check("frame_start", 32'(frame_start), 32'(fs_exp));
   endtask

   task automatic run_until(input int p);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (pos != p && n < LIMIT);
      if (pos != p) check("run_timeout", 32'(pos), 32'(p));
   endtask

   initial begin
      pix_t got;
      n_total  = 0;
      n_bad    = 0;
      e        = 0;
      pos      = 0;
      fs_model = 0;
      fs_dut   = 0;
      m_snap   = '0;
      mem_flat = '0;
      rst      = 1'b1;
      repeat (3) step();
      got = {vga_r, vga_g, vga_b, hsync, vsync};
      check("reset_pix", 32'(got), 32'(RST_PIX));
      check("reset_fs", 32'(frame_start), 32'd0);
      rst = 1'b0;
      step();
      got = {vga_r, vga_g, vga_b, hsync, vsync};
      check("pre_tick_pix", 32'(got), 32'(RST_PIX));
      check("pre_tick_fs", 32'(frame_start), 32'd0);

      // Frame 0 shows zeros; load A5 / 3C before the first capture
      run_until(200 * H_T);
      mem_flat[7:0]     = 8'hA5;
      mem_flat[167:160] = 8'h3C;

      // Frame 1 renders A5 / 3C; byte 0 changes mid-frame but must not show yet
      run_until(40 * H_T);
      mem_flat[7:0] = 8'hFF;
      run_until(0);

      // Frame 2 shows FF; then reset mid-frame
      run_until(60 * H_T);
      rst = 1'b1;
      step();
      got = {vga_r, vga_g, vga_b, hsync, vsync};
      check("mid_rst_pix", 32'(got), 32'(RST_PIX));
      check("mid_rst_fs", 32'(frame_start), 32'd0);
      repeat (2) step();
      rst = 1'b0;
      run_until(60 * H_T);

      check("fs_count", 32'(fs_dut), 32'(fs_model));
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
